io_bridge: RTL and testbench

- Sits between the CPU data-memory port and the data RAM and memory-mapped peripherals (LED, digit tube, switches, buttons).
- Decodes each CPU load/store into either the DRAM path or the peripheral region.
- Registers peripheral writes into a one-cycle-delayed write bus: io_addr, io_wen, io_wdata.
- Synchronises and debounces board inputs, and returns all read data with a uniform one-cycle latency.

---
 rtl/io_map_pkg.sv | 18 +
 rtl/io_bridge_if.sv | 24 ++
 rtl/io_bridge_btn_debounce.sv | 45 ++++
 rtl/io_bridge.sv | 118 +++++++++++
 tb/tb_io_bridge.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/io_map_pkg.sv
// Address map shared by the IO bridge and its sub-blocks: peripheral offsets,
// the default peripheral base and a helper for offsets that accept stores.
package io_map_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_F000;

   localparam logic [11:0] OFF_DIG = 12'h000;
   localparam logic [11:0] OFF_LED = 12'h060;
   localparam logic [11:0] OFF_SW  = 12'h070;
   localparam logic [11:0] OFF_BTN = 12'h078;
   localparam logic [11:0] OFF_ERR = 12'h07C;

   // Only the digit tube and the LEDs are writable; every other offset is an error.
   function automatic logic is_wr_mapped(input logic [11:0] off);
      return (off == OFF_DIG) || (off == OFF_LED);
   endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU data-port, DRAM and peripheral write bus bundled for the IO bridge.
// The master side is the CPU/board environment, the slave side is the bridge.
interface io_bridge_if;
   logic [31:0] cpu_addr;
   logic        cpu_wen;
   logic        cpu_ren;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        dram_we;
   logic [31:0] dram_rdata;
   logic [11:0] io_addr;
   logic        io_wen;
   logic [31:0] io_wdata;

   modport master (
      output cpu_addr, cpu_wen, cpu_ren, cpu_wdata, dram_rdata,
      input  cpu_rdata, dram_we, io_addr, io_wen, io_wdata
   );

   modport slave (
      input  cpu_addr, cpu_wen, cpu_ren, cpu_wdata, dram_rdata,
      output cpu_rdata, dram_we, io_addr, io_wen, io_wdata
   );
endinterface

// File: rtl/io_bridge_btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debouncer.
// The accepted state only flips after the synced level differs for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_state
);

   localparam logic [19:0] LAST_COUNT = DEBOUNCE_CYCLES - 20'd1;

   logic        sync1, sync2;
   logic        state_q;
   logic [19:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Any return to the accepted level restarts the count, so short glitches never land.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 1'b0;
         cnt_q   <= 20'd0;
      end else if (sync2 == state_q) begin
         cnt_q <= 20'd0;
      end else if (cnt_q == LAST_COUNT) begin
         state_q <= ~state_q;
         cnt_q   <= 20'd0;
      end else begin
         cnt_q <= cnt_q + 20'd1;
      end
   end

   assign btn_state = state_q;

endmodule

// File: rtl/io_bridge.sv
// Splits CPU loads/stores between DRAM and the peripheral region, registers
// peripheral writes, and returns every load with a fixed one-cycle latency.
module io_bridge
   import io_map_pkg::*;
#(
   parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000,
   parameter int          SW_W            = 24,
   parameter int          BTN_W           = 5
) (
   input  logic             clk,
   input  logic             rst,
   io_bridge_if.slave       bus,
   input  logic [SW_W-1:0]  sw_in,
   input  logic [BTN_W-1:0] btn_in
);

   logic             is_io;
   logic [11:0]      off;
   logic             io_store;
   logic             io_wen_q;
   logic [11:0]      io_addr_q;
   logic [31:0]      io_wdata_q;
   logic [23:0]      led_q;
   logic [31:0]      dig_q;
   logic [7:0]       err_cnt;
   logic             sel_io;
   logic [31:0]      io_rdata_q;
   logic [31:0]      rd_map;
   logic [SW_W-1:0]  sw_meta, sw_sync;
   logic [BTN_W-1:0] btn_db;

   assign is_io    = (bus.cpu_addr[31:12] == IO_BASE[31:12]);
   assign off      = bus.cpu_addr[11:0];
   assign io_store = bus.cpu_wen & is_io;

   assign bus.dram_we = bus.cpu_wen & ~is_io;

   // Peripheral write bus lags the store by one cycle; address/data hold between stores.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_wen_q   <= 1'b0;
         io_addr_q  <= 12'h000;
         io_wdata_q <= 32'h0;
      end else begin
         io_wen_q <= io_store & is_wr_mapped(off);
         if (io_store) begin
            io_addr_q  <= off;
            io_wdata_q <= bus.cpu_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q   <= 24'h0;
         dig_q   <= 32'h0;
         err_cnt <= 8'h00;
      end else if (io_store) begin
         if (off == OFF_LED)
            led_q <= bus.cpu_wdata[23:0];
         else if (off == OFF_DIG)
            dig_q <= bus.cpu_wdata;
         else if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   always_comb begin
      rd_map = 32'h0;
      case (off)
         OFF_SW:  rd_map = 32'(sw_sync);
         OFF_BTN: rd_map = 32'(btn_db);
         OFF_ERR: rd_map = {24'h0, err_cnt};
         OFF_LED: rd_map = {8'h0, led_q};
         OFF_DIG: rd_map = dig_q;
         default: rd_map = 32'h0;
      endcase
   end

   // Sampling the map on the same edge as a store gives read-before-write for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_io     <= 1'b0;
         io_rdata_q <= 32'h0;
      end else if (bus.cpu_ren) begin
         sel_io     <= is_io;
         io_rdata_q <= rd_map;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
      end
   end

   for (genvar b = 0; b < BTN_W; b++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk      (clk),
         .rst      (rst),
         .btn_raw  (btn_in[b]),
         .btn_state(btn_db[b])
      );
   end

   assign bus.cpu_rdata = sel_io ? io_rdata_q : bus.dram_rdata;
   assign bus.io_wen    = io_wen_q;
   assign bus.io_addr   = io_addr_q;
   assign bus.io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed scenarios plus randomized
// loads/stores scored against a register-level model of the peripheral map.
module tb_io_bridge;
   import io_map_pkg::*;

   localparam logic [19:0] DEB = 20'd8;

   logic       clk = 1'b0;
   logic       rst;
   logic [23:0] sw_in;
   logic [4:0]  btn_in;

   io_bridge_if bus ();

   io_bridge #(
      .IO_BASE        (32'hFFFF_F000),
      .DEBOUNCE_CYCLES(DEB),
      .SW_W           (24),
      .BTN_W          (5)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .sw_in (sw_in),
      .btn_in(btn_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [23:0] mLed;
   logic [31:0] mDig;
   int          mErr;
   logic [23:0] mSw;
   logic [4:0]  mBtn;
   logic [11:0] mIoAddr;
   logic [31:0] mIoWdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [11:0] off);
      case (off)
         OFF_SW:  return {8'h0, mSw};
         OFF_BTN: return {27'h0, mBtn};
         OFF_ERR: return 32'(mErr);
         OFF_LED: return {8'h0, mLed};
         OFF_DIG: return mDig;
         default: return 32'h0;
      endcase
   endfunction

   // One CPU access: drives the bus for one clock, then checks write bus and load data.
   task automatic access(input logic [31:0] addr, input logic wen, input logic ren,
                         input logic [31:0] data);
      logic        io;
      logic [11:0] off;
      logic [31:0] expRd;
      logic        expPulse;
      io       = (addr[31:12] == 20'hFFFFF);
      off      = addr[11:0];
      expRd    = io ? modelRead(off) : 32'h0;
      expPulse = wen && io && (off == OFF_DIG || off == OFF_LED);
      bus.cpu_addr  = addr;
      bus.cpu_wen   = wen;
      bus.cpu_ren   = ren;
      bus.cpu_wdata = data;
      #1;
      check("dram_we", {31'h0, bus.dram_we}, {31'h0, wen && !io});
      if (wen && io) begin
         mIoAddr  = off;
         mIoWdata = data;
         if (off == OFF_LED)      mLed = data[23:0];
         else if (off == OFF_DIG) mDig = data;
         else if (mErr < 255)     mErr++;
      end
      @(posedge clk);
      #1;
      bus.cpu_wen    = 1'b0;
      bus.cpu_ren    = 1'b0;
      bus.dram_rdata = $urandom;
      #1;
      check("io_wen", {31'h0, bus.io_wen}, {31'h0, expPulse});
      check("io_addr", {20'h0, bus.io_addr}, {20'h0, mIoAddr});
      check("io_wdata", bus.io_wdata, mIoWdata);
      if (ren)
         check($sformatf("rdata@%h", addr), bus.cpu_rdata, io ? expRd : bus.dram_rdata);
   endtask

   initial begin
      logic [31:0] a;
      logic [11:0] ioOffs [8];
      ioOffs = '{12'h000, 12'h060, 12'h070, 12'h078, 12'h07C, 12'h100, 12'hFFC, 12'h064};

      rst = 1'b1;
      sw_in = 24'h0;
      btn_in = 5'h0;
      bus.cpu_addr = 32'h0;
      bus.cpu_wen = 1'b0;
      bus.cpu_ren = 1'b0;
      bus.cpu_wdata = 32'h0;
      bus.dram_rdata = 32'h1234_5678;
      mLed = '0; mDig = '0; mErr = 0; mSw = '0; mBtn = '0; mIoAddr = '0; mIoWdata = '0;
      tick(3);
      check("rst_io_wen", {31'h0, bus.io_wen}, 32'h0);
      check("rst_io_addr", {20'h0, bus.io_addr}, 32'h0);
      check("rst_io_wdata", bus.io_wdata, 32'h0);
      check("rst_rdata", bus.cpu_rdata, 32'h1234_5678);
      @(negedge clk);
      rst = 1'b0;
      tick();

      access(32'hFFFF_F060, 1'b1, 1'b0, 32'h00AB_CDEF);
      tick();
      check("pulse_single", {31'h0, bus.io_wen}, 32'h0);
      access(32'hFFFF_F060, 1'b0, 1'b1, 32'h0);
      check("led_const", bus.cpu_rdata, 32'h00AB_CDEF);

      access(32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF);
      access(32'h0000_0010, 1'b0, 1'b1, 32'h0);

      sw_in = 24'h5A5A5A;
      tick(3);
      mSw = 24'h5A5A5A;
      access(32'hFFFF_F070, 1'b0, 1'b1, 32'h0);
      check("sw_const", bus.cpu_rdata, 32'h005A_5A5A);

      access(32'hFFFF_F000, 1'b1, 1'b0, 32'hCAFE_0001);
      access(32'hFFFF_F060, 1'b1, 1'b0, 32'h0011_2233);
      access(32'hFFFF_F000, 1'b0, 1'b1, 32'h0);
      access(32'hFFFF_F060, 1'b1, 1'b1, 32'h0044_5566);
      check("rbw_old_led", bus.cpu_rdata, 32'h0011_2233);

      access(32'hFFFF_F070, 1'b1, 1'b0, 32'h1);
      access(32'hFFFF_F070, 1'b1, 1'b0, 32'h2);
      access(32'hFFFF_F100, 1'b1, 1'b0, 32'h3);
      access(32'hFFFF_F07C, 1'b0, 1'b1, 32'h0);
      check("err_three", bus.cpu_rdata, 32'h3);

      btn_in[2] = 1'b1;
      tick(int'(DEB) - 2);
      btn_in[2] = 1'b0;
      tick(12);
      access(32'hFFFF_F078, 1'b0, 1'b1, 32'h0);
      check("btn_glitch", bus.cpu_rdata, 32'h0);
      btn_in[2] = 1'b1;
      tick(int'(DEB) + 3);
      mBtn = 5'b00100;
      access(32'hFFFF_F078, 1'b0, 1'b1, 32'h0);
      check("btn_held", bus.cpu_rdata, 32'h4);

      for (int i = 0; i < 150; i++) begin
         if (i % 30 == 29) begin
            sw_in = 24'($urandom);
            tick(3);
            mSw = sw_in;
         end
         if ($urandom_range(0, 2) == 0)
            a = {20'h0, 12'($urandom) & 12'hFFC};
         else
            a = {20'hFFFFF, ioOffs[$urandom_range(0, 7)]};
         access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      for (int i = 0; i < 300; i++)
         access(32'hFFFF_F070, 1'b1, 1'b0, $urandom);
      access(32'hFFFF_F07C, 1'b0, 1'b1, 32'h0);
      check("err_sat", bus.cpu_rdata, 32'h0000_00FF);

      btn_in = 5'h0;
      bus.cpu_addr  = 32'hFFFF_F060;
      bus.cpu_wdata = 32'h00FE_DCBA;
      bus.cpu_wen   = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_wen", {31'h0, bus.io_wen}, 32'h0);
      tick();
      check("rst_no_pulse", {31'h0, bus.io_wen}, 32'h0);
      check("rst_io_addr2", {20'h0, bus.io_addr}, 32'h0);
      bus.cpu_wen = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mLed = '0; mDig = '0; mErr = 0; mBtn = '0; mIoAddr = '0; mIoWdata = '0;
      tick(3);
      access(32'hFFFF_F060, 1'b0, 1'b1, 32'h0);
      check("rst_led", bus.cpu_rdata, 32'h0);
      access(32'hFFFF_F07C, 1'b0, 1'b1, 32'h0);
      check("rst_err", bus.cpu_rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
